// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the multicycle control unit.
//   state_t : FSM state encoding (3 bits, exported on cu_mc.state)
//   ctrl_t  : per-opcode control word produced by cu_decode
//   OP_*    : opcode constants (5-bit)
package cu_pkg;

    // Widest flag register the control word can describe.
    localparam int unsigned FLAG_MAX = 8;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        FETCH_REG = 3'd1,
        MEM_REQ   = 3'd2,
        MEM_SAVE  = 3'd3,
        EXECUTE   = 3'd4,
        FAULT     = 3'd5
    } state_t;

    typedef struct packed {
        logic                mem_op;      // needs a data-memory operand read
        logic                opnd_dst;    // operand goes to latch 1 (else latch 0)
        logic [2:0]          reg_re;      // register read ports 1..3
        logic [1:0]          op_re;       // operand latches in FETCH_REG
        logic                ri_re;       // index register read
        logic                reg_we;
        logic                mem_we;
        logic                result_src;
        logic                push;
        logic                pop;
        logic [FLAG_MAX-1:0] flag_mask;   // flags updated in EXECUTE
        logic                br_always;
        logic                br_cond_en;
        logic [2:0]          br_idx;      // flag tested by a conditional branch
    } ctrl_t;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b00001;
    localparam logic [4:0] OP_PUSH  = 5'b00011;
    localparam logic [4:0] OP_POP   = 5'b00100;
    localparam logic [4:0] OP_ADD   = 5'b00101;
    localparam logic [4:0] OP_JMP   = 5'b01110;
    localparam logic [4:0] OP_JS    = 5'b01111;
    localparam logic [4:0] OP_JG    = 5'b10000;
    localparam logic [4:0] OP_CMP   = 5'b10001;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: purely combinational opcode -> control word decoder.
//   opcode [OPCODE_W] in : opcode from the instruction register
//   ctrl   (ctrl_t)   out: control word; unknown opcodes give all zeros (no-op)
module cu_decode
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPCODE_W'(OP_LOAD): begin
                ctrl.ri_re      = 1'b1;
                ctrl.mem_op     = 1'b1;
                ctrl.result_src = 1'b1;
                ctrl.reg_we     = 1'b1;
            end
            OPCODE_W'(OP_STORE): begin
                ctrl.reg_re = 3'b001;
                ctrl.op_re  = 2'b01;
                ctrl.ri_re  = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            OPCODE_W'(OP_PUSH): begin
                ctrl.reg_re = 3'b001;
                ctrl.op_re  = 2'b01;
                ctrl.push   = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            OPCODE_W'(OP_POP): begin
                ctrl.mem_op     = 1'b1;
                ctrl.opnd_dst   = 1'b1;
                ctrl.pop        = 1'b1;
                ctrl.result_src = 1'b1;
                ctrl.reg_we     = 1'b1;
            end
            OPCODE_W'(OP_ADD): begin
                ctrl.reg_re    = 3'b001;
                ctrl.op_re     = 2'b01;
                ctrl.reg_we    = 1'b1;
                ctrl.flag_mask = FLAG_MAX'(1);
            end
            OPCODE_W'(OP_JMP): begin
                ctrl.br_always = 1'b1;
            end
            OPCODE_W'(OP_JS): begin
                ctrl.br_cond_en = 1'b1;
                ctrl.br_idx     = 3'd0;
            end
            OPCODE_W'(OP_JG): begin
                ctrl.br_cond_en = 1'b1;
                ctrl.br_idx     = 3'd1;
            end
            OPCODE_W'(OP_CMP): begin
                ctrl.reg_re    = 3'b011;
                ctrl.op_re     = 2'b11;
                ctrl.flag_mask = FLAG_MAX'(3);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_mc.sv
// cu_mc: parametrised multicycle control unit.
// Sequences FETCH (INSTR_WORDS ready/valid beats) -> FETCH_REG ->
// [MEM_REQ -> MEM_SAVE] -> EXECUTE, driving all datapath enables
// combinationally from the registered state and the decode word.
// Optional feature macro: CU_TIMEOUT_EN (per-beat memory timeout -> FAULT).
// Ports:
//   clk, rst_n (sync, active-low)   opcode, flag_in, mem_ready, hold (inputs)
//   mem_req, instr_re, opnd_re, mem_we, reg_re, reg_we, op_re, ri_re,
//   result_src, pc_en, pc_src, instr_write, push, pop   (combinational strobes)
//   flags (registered), state (FSM encoding), fault (sticky timeout fault)
module cu_mc
    import cu_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 5,
    parameter int unsigned INSTR_WORDS = 3,
    parameter int unsigned FLAG_N      = 2,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPCODE_W-1:0]    opcode,
    input  logic [FLAG_N-1:0]      flag_in,
    input  logic                   mem_ready,
    input  logic                   hold,
    output logic                   mem_req,
    output logic [INSTR_WORDS-1:0] instr_re,
    output logic                   opnd_re,
    output logic                   mem_we,
    output logic [2:0]             reg_re,
    output logic                   reg_we,
    output logic [1:0]             op_re,
    output logic                   ri_re,
    output logic                   result_src,
    output logic                   pc_en,
    output logic                   pc_src,
    output logic                   instr_write,
    output logic                   push,
    output logic                   pop,
    output logic [FLAG_N-1:0]      flags,
    output logic [2:0]             state,
    output logic                   fault
);

    localparam int unsigned BEAT_W = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INSTR_WORDS - 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [FLAG_N-1:0]   flags_q, flags_d;
    logic [FLAG_N-1:0]   mask;
    logic [FLAG_MAX-1:0] flags_ext;
    logic                br_taken;
    logic                timeout_hit;
    logic                unused_ctrl;
    ctrl_t               ctrl;

    cu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    // Flag mask is carried at full width; only the low FLAG_N bits matter here.
    assign unused_ctrl = ^ctrl.flag_mask;
    assign mask        = ctrl.flag_mask[FLAG_N-1:0];

    // Branch tests the flags as held before the EXECUTE edge.
    assign flags_ext = FLAG_MAX'(flags_q);
    assign br_taken  = ctrl.br_always | (ctrl.br_cond_en & flags_ext[ctrl.br_idx]);

`ifdef CU_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q;
    logic            waiting;

    assign waiting     = ((state_q == FETCH) || (state_q == MEM_REQ)) && !mem_ready;
    // Hit on the wait cycle that brings the count to TIMEOUT_CYC.
    assign timeout_hit = waiting && (to_q == TO_W'(TIMEOUT_CYC - 1));
    assign fault       = (state_q == FAULT);

    always_ff @(posedge clk) begin
        if (!rst_n)      to_q <= '0;
        else if (!hold)  to_q <= waiting ? to_q + 1'b1 : '0;
    end
`else
    logic unused_to;
    assign unused_to   = (TIMEOUT_CYC == 0);
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            beat_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flags_q <= flags_d;
        end
    end

    // Next state; hold keeps every register at its current value.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flags_d = flags_q;
        if (!hold) begin
            case (state_q)
                FETCH: begin
                    if (timeout_hit) begin
                        state_d = FAULT;
                    end else if (mem_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = '0;
                            state_d = FETCH_REG;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                FETCH_REG: state_d = ctrl.mem_op ? MEM_REQ : EXECUTE;
                MEM_REQ: begin
                    if (timeout_hit)    state_d = FAULT;
                    else if (mem_ready) state_d = MEM_SAVE;
                end
                MEM_SAVE: state_d = EXECUTE;
                EXECUTE: begin
                    flags_d = (flags_q & ~mask) | (flag_in & mask);
                    beat_d  = '0;
                    state_d = FETCH;
                end
                FAULT:   state_d = FAULT;
                default: state_d = FETCH;
            endcase
        end
    end

    // Outputs
    always_comb begin
        mem_req     = 1'b0;
        instr_re    = '0;
        opnd_re     = 1'b0;
        mem_we      = 1'b0;
        reg_re      = '0;
        reg_we      = 1'b0;
        op_re       = '0;
        ri_re       = 1'b0;
        result_src  = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        instr_write = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        if (rst_n && !hold) begin
            case (state_q)
                FETCH: begin
                    mem_req     = 1'b1;
                    instr_re    = INSTR_WORDS'(1) << beat_q;
                    instr_write = 1'b1;
                    pc_en       = mem_ready;
                end
                FETCH_REG: begin
                    reg_re = ctrl.reg_re;
                    op_re  = ctrl.op_re;
                    ri_re  = ctrl.ri_re;
                end
                MEM_REQ: begin
                    mem_req = 1'b1;
                    opnd_re = 1'b1;
                end
                MEM_SAVE: op_re = ctrl.opnd_dst ? 2'b10 : 2'b01;
                EXECUTE: begin
                    reg_we     = ctrl.reg_we;
                    mem_we     = ctrl.mem_we;
                    result_src = ctrl.result_src;
                    push       = ctrl.push;
                    pop        = ctrl.pop;
                    pc_en      = br_taken;
                    pc_src     = br_taken;
                end
                default: ;
            endcase
        end
    end

    assign flags = flags_q;
    assign state = state_q;

endmodule
